// File: rtl/fact_ctrl.sv
// fact_ctrl: iterative factorial engine sequenced by an external magnitude comparator
//
// Ports:
//   clk     - rising-edge clock
//   rst     - asynchronous active-high reset; returns to IDLE and clears cnt/product
//   go      - start request, honoured only in IDLE, DONE or ERR
//   n       - operand, sampled only on the edge that accepts go
//   gt      - comparator result for cmp_a > cmp_b, combinational in the same cycle
//   cmp_a   - down-counter, zero-extended, to comparator input A
//   cmp_b   - constant 1, to comparator input B
//   busy    - high in CHECK and MULT
//   done    - high in DONE; product valid
//   err     - high in ERR (n exceeded MAX_N)
//   product - product register; shows partial results while busy
module fact_ctrl #(
    parameter int WIDTH = 32,
    parameter int NW    = 4,
    parameter int MAX_N = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             go,
    input  logic [NW-1:0]    n,
    input  logic             gt,
    output logic [WIDTH-1:0] cmp_a,
    output logic [WIDTH-1:0] cmp_b,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] product
);
    typedef enum logic [2:0] {IDLE, CHECK, MULT, DONE, ERR} state_t;

    state_t            state_q, state_d;
    logic [NW-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]  product_q, product_d;
    logic              too_big;

    assign too_big = int'(n) > MAX_N;
    // The loop test cnt > 1 is delegated to the external comparator via cmp_a/cmp_b/gt.
    assign cmp_a   = WIDTH'(cnt_q);
    assign cmp_b   = WIDTH'(1);
    assign product = product_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        case (state_q)
            IDLE, DONE, ERR: begin
                if (go) begin
                    if (too_big) begin
                        state_d = ERR;
                    end else begin
                        state_d   = CHECK;
                        cnt_d     = n;
                        product_d = WIDTH'(1);
                    end
                end
            end
            CHECK: state_d = gt ? MULT : DONE;
            MULT: begin
                product_d = product_q * cmp_a;
                cnt_d     = cnt_q - NW'(1);
                state_d   = CHECK;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == CHECK) || (state_q == MULT);
        done = state_q == DONE;
        err  = state_q == ERR;
    end
endmodule

// File: tb/tb_fact_ctrl.sv
// tb_fact_ctrl: directed self-checking bench for fact_ctrl with a behavioural comparator
module tb_fact_ctrl;
    localparam int WIDTH = 32;
    localparam int NW    = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             go  = 1'b0;
    logic [NW-1:0]    n   = '0;
    logic             gt;
    logic [WIDTH-1:0] cmp_a, cmp_b, product;
    logic             busy, done, err;
    int               n_checks = 0;
    int               n_pass   = 0;

    assign gt = cmp_a > cmp_b;

    always #5 clk = ~clk;

    fact_ctrl #(.WIDTH(WIDTH), .NW(NW), .MAX_N(12)) dut (
        .clk(clk), .rst(rst), .go(go), .n(n), .gt(gt),
        .cmp_a(cmp_a), .cmp_b(cmp_b), .busy(busy), .done(done),
        .err(err), .product(product)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic [NW-1:0] v);
        go = 1'b1;
        n  = v;
        tick();
        go = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int lat, input logic [31:0] prod);
        int c = 0;
        while (!done && c < 100) begin
            tick();
            c++;
        end
        check({tag, " latency"}, 64'(c), 64'(lat));
        check({tag, " done"}, 64'(done), 64'd1);
        check({tag, " product"}, 64'(product), 64'(prod));
    endtask

    initial begin
        tick();
        tick();
        #2 rst = 1'b1;
        #1;
        check("async rst flags", {busy, done, err}, 3'b000);
        check("async rst product", 64'(product), 64'd0);
        tick();
        rst = 1'b0;
        repeat (3) tick();
        check("idle flags", {busy, done, err}, 3'b000);
        check("cmp_b const", 64'(cmp_b), 64'd1);

        start(4'd5);
        check("n5 busy", 64'(busy), 64'd1);
        wait_done("n5", 9, 32'd120);
        for (int i = 0; i < 20; i++) begin
            tick();
            check("n5 hold", {busy, done, product}, {2'b01, 32'd120});
        end

        start(4'd0);
        check("n0 busy", 64'(busy), 64'd1);
        wait_done("n0", 1, 32'd1);
        start(4'd1);
        wait_done("n1", 1, 32'd1);
        start(4'd12);
        wait_done("n12", 23, 32'h1C8CFC00);

        start(4'd13);
        check("n13 flags", {err, done, busy}, 3'b100);
        check("n13 product", 64'(product), 64'h1C8CFC00);
        repeat (3) tick();
        check("n13 hold", {err, done, busy}, 3'b100);
        start(4'd3);
        check("n3 leaves err", {err, busy}, 2'b01);
        wait_done("n3", 5, 32'd6);

        start(4'd6);
        go = 1'b1;
        n  = 4'd2;
        tick();
        go = 1'b0;
        n  = 4'd9;
        check("n6 still busy", 64'(busy), 64'd1);
        wait_done("n6", 10, 32'd720);

        start(4'd4);
        tick();
        check("n4 in mult", {busy, 32'(cmp_a)}, {1'b1, 32'd4});
        #2 rst = 1'b1;
        #1;
        check("mid rst flags", {busy, done, err}, 3'b000);
        check("mid rst product", 64'(product), 64'd0);
        #1 rst = 1'b0;
        tick();
        check("post rst idle", {busy, done, err}, 3'b000);
        start(4'd4);
        wait_done("n4 after rst", 7, 32'd24);

        go = 1'b1;
        n  = 4'd4;
        tick();
        for (int r = 0; r < 3; r++) begin
            wait_done("b2b", 7, 32'd24);
            tick();
            check("b2b restart", {done, busy}, 2'b01);
        end
        go = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
